// File: rtl/evt_buffer_pkg.sv
// Shared types and width helpers for the event buffer and its FIFO.
package evt_buffer_pkg;

    typedef enum logic {
        PASS = 1'b0,
        DROP = 1'b1
    } state_t;

    // Occupancy needs one extra bit to represent a completely full FIFO.
    function automatic int lvl_bits(input int depth_bits);
        return depth_bits + 1;
    endfunction

    function automatic int tmr_bits(input int drop_wait);
        return (drop_wait < 2) ? 1 : $clog2(drop_wait);
    endfunction

endpackage

// File: rtl/evt_buffer_if.sv
// Event stream bundle: processor-side input and packet-assembler-side output.
interface evt_buffer_if #(
    parameter int EVT_BITS = 32
);
    logic [EVT_BITS-1:0] evt_data_in;
    logic                evt_vld_in;
    logic                evt_rdy_out;
    logic [EVT_BITS-1:0] evt_data_out;
    logic                evt_vld_out;
    logic                evt_rdy_in;

    modport slave (
        input  evt_data_in,
        input  evt_vld_in,
        input  evt_rdy_in,
        output evt_rdy_out,
        output evt_data_out,
        output evt_vld_out
    );

    modport master (
        output evt_data_in,
        output evt_vld_in,
        output evt_rdy_in,
        input  evt_rdy_out,
        input  evt_data_out,
        input  evt_vld_out
    );
endinterface

// File: rtl/evt_fifo.sv
// Synchronous FIFO with a registered head word; a write into an empty FIFO
// is visible on o_rd_data one cycle later.
module evt_fifo
    import evt_buffer_pkg::*;
#(
    parameter int EVT_BITS   = 32,
    parameter int DEPTH_BITS = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_wr,
    input  logic [EVT_BITS-1:0]             i_wr_data,
    input  logic                            i_rd,
    output logic [EVT_BITS-1:0]             o_rd_data,
    output logic [lvl_bits(DEPTH_BITS)-1:0] o_level,
    output logic                            o_full,
    output logic                            o_empty
);
    localparam int LVL_W = lvl_bits(DEPTH_BITS);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [EVT_BITS-1:0]   r_mem [DEPTH];
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [DEPTH_BITS-1:0] w_rd_ptr_next;
    logic [LVL_W-1:0]      r_level;
    logic [EVT_BITS-1:0]   r_rd_data;
    logic                  w_do_wr;
    logic                  w_do_rd;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == FULL_LVL);
    assign o_level = r_level;
    assign o_rd_data = r_rd_data;

    // A write while full is only allowed when the head leaves in the same cycle.
    assign w_do_rd = i_rd && !o_empty;
    assign w_do_wr = i_wr && (!o_full || w_do_rd);
    assign w_rd_ptr_next = w_do_rd ? r_rd_ptr + 1'b1 : r_rd_ptr;

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Head register reads the next head address; bypass when the incoming word becomes the head.
    always_ff @(posedge clk) begin
        if (w_do_wr && (r_wr_ptr == w_rd_ptr_next)) begin
            r_rd_data <= i_wr_data;
        end else begin
            r_rd_data <= r_mem[w_rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_ptr_next;
            case ({w_do_wr, w_do_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/evt_buffer.sv
// Elastic event buffer: FIFO plus a stall-triggered drop mode that discards
// events instead of back-pressuring the source while the output is stuck.
module evt_buffer
    import evt_buffer_pkg::*;
#(
    parameter int EVT_BITS   = 32,
    parameter int DEPTH_BITS = 4,
    parameter int DROP_WAIT  = 256,
    parameter int CNT_BITS   = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    evt_buffer_if.slave                     bus,
    input  logic                            drop_en_in,
    input  logic                            clr_cnt_in,
    output logic [CNT_BITS-1:0]             drop_cnt_out,
    output logic [lvl_bits(DEPTH_BITS)-1:0] level_out,
    output logic                            dropping_out
);
    localparam int TMR_W = tmr_bits(DROP_WAIT);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(DROP_WAIT - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [TMR_W-1:0]      r_timer;
    logic [CNT_BITS-1:0]   r_cnt;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rdy;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_stall;
    logic                  w_drop;

    evt_fifo #(
        .EVT_BITS   (EVT_BITS),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr      (w_push),
        .i_wr_data (bus.evt_data_in),
        .i_rd      (w_pop),
        .o_rd_data (bus.evt_data_out),
        .o_level   (level_out),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign bus.evt_vld_out = !w_empty;
    assign bus.evt_rdy_out = w_rdy;
    assign w_push  = bus.evt_vld_in && w_rdy;
    assign w_pop   = !w_empty && bus.evt_rdy_in;
    assign w_stall = !w_empty && !bus.evt_rdy_in && drop_en_in;
    // Only reachable in DROP: the source is always accepted, so a full FIFO discards.
    assign w_drop  = w_push && w_full && !w_pop;

    assign drop_cnt_out = r_cnt;
    assign dropping_out = (r_state == DROP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PASS;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rdy        = 1'b0;
        case (r_state)
            PASS: begin
                w_rdy = !w_full;
                if (w_stall && (r_timer == TMR_MAX)) begin
                    w_state_next = DROP;
                end
            end
            DROP: begin
                w_rdy = 1'b1;
                if (w_pop || !drop_en_in) begin
                    w_state_next = PASS;
                end
            end
            default: w_state_next = PASS;
        endcase
        if (reset) begin
            w_rdy = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_pop || !drop_en_in) begin
            r_timer <= '0;
        end else if (w_stall && (r_timer != TMR_MAX)) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_cnt_in) begin
            r_cnt <= '0;
        end else if (w_drop && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_evt_buffer.sv
// Directed bench for evt_buffer with a queue scoreboard and cycle reference model.
module tb_evt_buffer;
    localparam int DEPTH     = 16;
    localparam int DROP_WAIT = 256;
    localparam int SAT_MAX   = 15;

    logic        clk;
    logic        rst;
    logic        drop_en;
    logic        clr_cnt;
    logic [31:0] drop_cnt;
    logic [4:0]  level;
    logic        dropping;
    logic [3:0]  sat_cnt;
    logic [4:0]  sat_level;
    logic        sat_dropping;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_q[$];
    bit          m_drop;
    int          m_timer;
    logic [31:0] m_cnt;
    int          m_sat;
    bit          last_acc;
    logic [31:0] next_data;

    evt_buffer_if #(.EVT_BITS(32)) bus ();
    evt_buffer_if #(.EVT_BITS(32)) bus2 ();

    assign bus2.evt_data_in = bus.evt_data_in;
    assign bus2.evt_vld_in  = bus.evt_vld_in;
    assign bus2.evt_rdy_in  = bus.evt_rdy_in;

    evt_buffer #(
        .EVT_BITS(32), .DEPTH_BITS(4), .DROP_WAIT(DROP_WAIT), .CNT_BITS(32)
    ) dut (
        .clk          (clk),
        .reset        (rst),
        .bus          (bus),
        .drop_en_in   (drop_en),
        .clr_cnt_in   (clr_cnt),
        .drop_cnt_out (drop_cnt),
        .level_out    (level),
        .dropping_out (dropping)
    );

    // Narrow drop counter instance so saturation is reachable in a short run.
    evt_buffer #(
        .EVT_BITS(32), .DEPTH_BITS(4), .DROP_WAIT(DROP_WAIT), .CNT_BITS(4)
    ) u_sat (
        .clk          (clk),
        .reset        (rst),
        .bus          (bus2),
        .drop_en_in   (drop_en),
        .clr_cnt_in   (clr_cnt),
        .drop_cnt_out (sat_cnt),
        .level_out    (sat_level),
        .dropping_out (sat_dropping)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check ready, predict the edge, then check registered outputs.
    task automatic tick();
        bit exp_rdy, vld_o, pop, push, stall, drop_evt, drop_n;
        logic [31:0] din;
        #2;
        exp_rdy  = rst ? 1'b0 : (m_drop || (m_q.size() < DEPTH));
        vld_o    = (m_q.size() != 0);
        pop      = vld_o && bus.evt_rdy_in;
        push     = bus.evt_vld_in && exp_rdy;
        stall    = vld_o && !bus.evt_rdy_in && drop_en;
        drop_evt = push && (m_q.size() == DEPTH) && !pop;
        din      = bus.evt_data_in;
        chk("rdy_out", 64'(bus.evt_rdy_out), 64'(exp_rdy));
        chk("sat_rdy_out", 64'(bus2.evt_rdy_out), 64'(exp_rdy));
        if (pop) begin
            chk("pop_data", 64'(bus.evt_data_out), 64'(m_q[0]));
            $display("pop  data=%08h level=%0d", bus.evt_data_out, level);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_q.delete();
            m_drop  = 1'b0;
            m_timer = 0;
            m_cnt   = '0;
            m_sat   = 0;
        end else begin
            if (!m_drop) drop_n = stall && (m_timer == DROP_WAIT - 1);
            else         drop_n = !pop && drop_en;
            if (pop || !drop_en) m_timer = 0;
            else if (stall && (m_timer < DROP_WAIT - 1)) m_timer++;
            if (clr_cnt) begin
                m_cnt = '0;
                m_sat = 0;
            end else if (drop_evt) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                if (m_sat != SAT_MAX) m_sat++;
            end
            if (pop) void'(m_q.pop_front());
            if (push && !drop_evt) m_q.push_back(din);
            m_drop = drop_n;
        end
        last_acc = push;
        if (push) next_data = next_data + 32'd1;
        bus.evt_data_in = next_data;
        chk("level", 64'(level), 64'(m_q.size()));
        chk("sat_level", 64'(sat_level), 64'(m_q.size()));
        chk("vld_out", 64'(bus.evt_vld_out), 64'(m_q.size() != 0));
        chk("sat_vld_out", 64'(bus2.evt_vld_out), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("head_data", 64'(bus.evt_data_out), 64'(m_q[0]));
            chk("sat_head_data", 64'(bus2.evt_data_out), 64'(m_q[0]));
        end
        chk("dropping", 64'(dropping), 64'(m_drop));
        chk("sat_dropping", 64'(sat_dropping), 64'(m_drop));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_cnt));
        chk("sat_drop_cnt", 64'(sat_cnt), 64'(m_sat));
    endtask

    task automatic run(input int cycles, input bit vld);
        bus.evt_vld_in  = vld;
        bus.evt_data_in = next_data;
        for (int k = 0; k < cycles; k++) tick();
    endtask

    initial begin
        rst = 1'b1; drop_en = 1'b0; clr_cnt = 1'b0;
        bus.evt_vld_in = 1'b0; bus.evt_data_in = '0; bus.evt_rdy_in = 1'b0;
        m_drop = 1'b0; m_timer = 0; m_cnt = '0; m_sat = 0; next_data = '0; last_acc = 1'b0;

        // Reset state
        run(2, 1'b1);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_vld", 64'(bus.evt_vld_out), 64'd0);
        chk("rst_rdy_gated", 64'(bus.evt_rdy_out), 64'd0);
        rst = 1'b0;

        // Streaming pass-through with the sink always ready
        bus.evt_rdy_in = 1'b1;
        next_data = 32'h1;
        run(1, 1'b1);
        chk("first_latency_vld", 64'(bus.evt_vld_out), 64'd1);
        chk("first_latency_data", 64'(bus.evt_data_out), 64'h1);
        for (int k = 0; k < 15; k++) begin
            run(1, 1'b1);
            chk("stream_level_le1", 64'(level <= 5'd1), 64'd1);
        end
        run(3, 1'b0);
        chk("stream_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("stream_empty", 64'(level), 64'd0);

        // Back-pressure without drop mode: fill to 16, then drain and accept the rest
        bus.evt_rdy_in = 1'b0;
        next_data = 32'h100;
        run(20, 1'b1);
        chk("bp_full_level", 64'(level), 64'd16);
        chk("bp_rdy_low", 64'(bus.evt_rdy_out), 64'd0);
        bus.evt_rdy_in = 1'b1;
        for (int k = 0; k < 60 && next_data != 32'h114; k++) run(1, 1'b1);
        chk("bp_rest_accepted", 64'(next_data), 64'h114);
        for (int k = 0; k < 40 && m_q.size() != 0; k++) run(1, 1'b0);
        chk("bp_drained", 64'(level), 64'd0);
        chk("bp_no_drops", 64'(drop_cnt), 64'd0);

        // Drop mode: 300 cycles of pushes into a stalled sink
        bus.evt_rdy_in = 1'b0;
        drop_en = 1'b1;
        next_data = 32'h200;
        bus.evt_vld_in = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            bus.evt_data_in = next_data;
            tick();
            if (k == 256) chk("drop_not_yet", 64'(dropping), 64'd0);
            if (k == 257) chk("drop_rise", 64'(dropping), 64'd1);
        end
        chk("drop_rdy_high", 64'(bus.evt_rdy_out), 64'd1);
        chk("drop_count_43", 64'(drop_cnt), 64'd43);
        chk("sat_count_stuck", 64'(sat_cnt), 64'd15);
        bus.evt_rdy_in = 1'b1;
        run(1, 1'b0);
        chk("pop_exits_drop", 64'(dropping), 64'd0);
        bus.evt_rdy_in = 1'b0;

        // Counter clear racing a dropped event
        clr_cnt = 1'b1;
        run(1, 1'b0);
        clr_cnt = 1'b0;
        chk("clr_cnt", 64'(drop_cnt), 64'd0);
        for (int k = 0; k < 400 && !m_drop; k++) run(1, 1'b1);
        chk("reenter_drop", 64'(dropping), 64'd1);
        run(5, 1'b1);
        chk("five_drops", 64'(drop_cnt), 64'd5);
        clr_cnt = 1'b1;
        run(1, 1'b1);
        clr_cnt = 1'b0;
        chk("clr_beats_inc", 64'(drop_cnt), 64'd0);
        chk("sat_clr_beats_inc", 64'(sat_cnt), 64'd0);

        // Reset with 10 events buffered in DROP
        drop_en = 1'b0;
        bus.evt_rdy_in = 1'b1;
        for (int k = 0; k < 40 && m_q.size() != 0; k++) run(1, 1'b0);
        bus.evt_rdy_in = 1'b0;
        drop_en = 1'b1;
        next_data = 32'h400;
        run(10, 1'b1);
        for (int k = 0; k < 400 && !m_drop; k++) run(1, 1'b0);
        chk("drop_with_10", 64'(dropping), 64'd1);
        chk("level_10", 64'(level), 64'd10);
        rst = 1'b1;
        run(1, 1'b1);
        chk("rst_flush_level", 64'(level), 64'd0);
        chk("rst_flush_vld", 64'(bus.evt_vld_out), 64'd0);
        chk("rst_flush_state", 64'(dropping), 64'd0);
        chk("rst_flush_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_rdy_low", 64'(bus.evt_rdy_out), 64'd0);
        run(1, 1'b1);
        rst = 1'b0;
        run(2, 1'b1);
        chk("post_rst_level", 64'(level), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
